spi_weight_fetch: RTL and testbench

Command sequencer directly upstream of the byte-level SPI master. It turns a "fetch N weight bytes from flash address A" request into a sequence of single-byte SPI transfers: read opcode, address bytes MSB first, then N dummy-byte reads. It hands each received byte to the ANN weight path over a valid/ready stream, and applies backpressure by not starting the next transfer.

---
 rtl/spi_weight_fetch.sv | 175 +++++++++++++++++
 tb/tb_spi_weight_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_weight_fetch.sv
// Weight fetch sequencer: read opcode, address bytes, then N data reads over a byte SPI master.
// Optional watchdog on SPI completion enabled by SPI_FETCH_TIMEOUT_EN.
module spi_weight_fetch #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0] CMD_READ       = 'h03,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic [7:0]            fetch_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  spi_start,
    output logic [DATA_WIDTH-1:0] spi_tx_data,
    input  logic                  spi_ready,
    input  logic [DATA_WIDTH-1:0] spi_rx_data,
    output logic                  wt_valid,
    output logic [DATA_WIDTH-1:0] wt_data,
    input  logic                  wt_ready
);

    localparam int NAB = ADDR_WIDTH / DATA_WIDTH;
    localparam int ABW = $clog2(NAB + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_WAIT,
        S_HOLD,
        S_FIN
    } state_t;

    state_t                  state_q;
    state_t                  kind_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [ABW-1:0]          abyte_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    start_q;
    logic [DATA_WIDTH-1:0]   tx_q;
    logic                    wt_valid_q;
    logic [DATA_WIDTH-1:0]   wt_data_q;

`ifdef SPI_FETCH_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic            err_q;
    logic [WDW-1:0]  wd_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Outputs are registered; each send state is entered with its strobe already set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            kind_q     <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            abyte_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            tx_q       <= '0;
            wt_valid_q <= 1'b0;
            wt_data_q  <= '0;
`ifdef SPI_FETCH_TIMEOUT_EN
            err_q      <= 1'b0;
            wd_q       <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (fetch_req) begin
                        addr_q  <= fetch_addr;
                        len_q   <= fetch_len;
                        abyte_q <= '0;
                        busy_q  <= 1'b1;
`ifdef SPI_FETCH_TIMEOUT_EN
                        err_q   <= 1'b0;
                        wd_q    <= '0;
`endif
                        if (fetch_len == 8'd0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_CMD;
                            start_q <= 1'b1;
                            tx_q    <= CMD_READ;
                        end
                    end
                end
                S_CMD, S_ADDR, S_DATA: begin
                    kind_q  <= state_q;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_ready) begin
                        if (kind_q == S_DATA) begin
                            wt_data_q  <= spi_rx_data;
                            wt_valid_q <= 1'b1;
                            state_q    <= S_HOLD;
                        end else if (kind_q == S_CMD ||
                                     abyte_q != ABW'(NAB)) begin
                            state_q <= S_ADDR;
                            start_q <= 1'b1;
                            tx_q    <= addr_q[ADDR_WIDTH-1 -: DATA_WIDTH];
                            addr_q  <= addr_q << DATA_WIDTH;
                            abyte_q <= abyte_q + 1'b1;
`ifdef SPI_FETCH_TIMEOUT_EN
                            wd_q    <= '0;
`endif
                        end else begin
                            state_q <= S_DATA;
                            start_q <= 1'b1;
                            tx_q    <= '0;
`ifdef SPI_FETCH_TIMEOUT_EN
                            wd_q    <= '0;
`endif
                        end
                    end
`ifdef SPI_FETCH_TIMEOUT_EN
                    else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                        state_q    <= S_FIN;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        wt_valid_q <= 1'b0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (wt_ready) begin
                        wt_valid_q <= 1'b0;
                        len_q      <= len_q - 8'd1;
                        if (len_q == 8'd1) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                            start_q <= 1'b1;
                            tx_q    <= '0;
`ifdef SPI_FETCH_TIMEOUT_EN
                            wd_q    <= '0;
`endif
                        end
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign spi_start   = start_q;
    assign spi_tx_data = tx_q;
    assign wt_valid    = wt_valid_q;
    assign wt_data     = wt_data_q;

endmodule

// File: tb/tb_spi_weight_fetch.sv
// Bench for spi_weight_fetch: SPI slave model, stream sink and transaction-level reference.
// Watchdog checks compile in when SPI_FETCH_TIMEOUT_EN is defined.
module tb_spi_weight_fetch;

    localparam int NAB = 2;
    localparam int TO  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic [7:0]  fetch_len = '0;
    logic        busy, done, err, spi_start;
    logic [7:0]  spi_tx_data;
    logic        spi_ready = 1'b0;
    logic [7:0]  spi_rx_data = '0;
    logic        wt_valid;
    logic [7:0]  wt_data;
    logic        wt_ready = 1'b0;

    always #5 clk = ~clk;

    spi_weight_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_len   (fetch_len),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_ready   (spi_ready),
        .spi_rx_data (spi_rx_data),
        .wt_valid    (wt_valid),
        .wt_data     (wt_data),
        .wt_ready    (wt_ready)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_log[$];
    logic [7:0] rx_log[$];
    logic [7:0] wt_log[$];
    logic [7:0] rx_src[$];
    int start_cnt, done_cnt, valid_cnt;
    int overlap_viol, stall_viol, hold_viol;
    int lat_min = 0;
    int lat_max = 3;
    bit resp_en = 1'b1;
    int rmode = 0;
    int stall_left = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SPI slave, stream sink and protocol monitor; all act on the falling edge.
    initial begin
        int cnt;
        logic [7:0] cur_tx, rd, pd;
        logic pv;
        cnt = 0;
        pv = 1'b0;
        cur_tx = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            spi_ready = 1'b0;
            case (rmode)
                1: wt_ready = 1'($urandom_range(1, 0));
                2: begin
                    if (stall_left > 0) begin
                        wt_ready = 1'b0;
                        if (wt_valid) stall_left--;
                    end else begin
                        wt_ready = 1'b1;
                    end
                end
                default: wt_ready = 1'b1;
            endcase
            if (!rst_n) begin
                cnt = 0;
                pv = 1'b0;
                continue;
            end
            if (done) done_cnt++;
            if (wt_valid) valid_cnt++;
            if (spi_start && wt_valid) overlap_viol++;
            if (pv && (wt_valid !== 1'b1 || wt_data !== pd)) stall_viol++;
            pv = wt_valid && !wt_ready;
            pd = wt_data;
            if (wt_valid && wt_ready) wt_log.push_back(wt_data);
            if (spi_start) begin
                start_cnt++;
                tx_log.push_back(spi_tx_data);
                cur_tx = spi_tx_data;
                if (resp_en) cnt = $urandom_range(lat_max, lat_min) + 1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (spi_tx_data !== cur_tx) hold_viol++;
                    if (rx_src.size() > 0) rd = rx_src.pop_front();
                    else rd = 8'($urandom);
                    rx_log.push_back(rd);
                    spi_rx_data = rd;
                    spi_ready = 1'b1;
                end
            end
        end
    end

    task automatic clear_logs();
        tx_log.delete();
        rx_log.delete();
        wt_log.delete();
        start_cnt = 0;
        done_cnt = 0;
        valid_cnt = 0;
        overlap_viol = 0;
        stall_viol = 0;
        hold_viol = 0;
    endtask

    task automatic fetch(input logic [15:0] a, input logic [7:0] n);
        @(posedge clk);
        #2;
        fetch_req = 1'b1;
        fetch_addr = a;
        fetch_len = n;
        @(posedge clk);
        #2;
        fetch_req = 1'b0;
        fetch_addr = 16'($urandom);
        fetch_len = 8'($urandom);
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int c;
        bit found;
        found = 1'b0;
        c = 0;
        while (c < 5000 && !found) begin
            @(negedge clk);
            c++;
            if (done === 1'b1) found = 1'b1;
        end
        chk({tag, "_done_seen"}, found, 1'b1);
        chk({tag, "_busy_with_done"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, "_busy_after_done"}, busy, 1'b0);
        chk({tag, "_done_one_cycle"}, done, 1'b0);
        #1;
    endtask

    // Reference: opcode, address MSB first, then n dummy bytes; data bytes are the
    // slave replies to the dummy transfers, delivered in order.
    task automatic check_fetch(input string tag, input logic [15:0] a,
                               input int n);
        logic [7:0] exp_tx[$];
        logic [15:0] sh;
        exp_tx.push_back(8'h03);
        for (int i = 0; i < NAB; i++) begin
            sh = a >> (8 * (NAB - 1 - i));
            exp_tx.push_back(sh[7:0]);
        end
        for (int i = 0; i < n; i++) exp_tx.push_back(8'h00);
        chk({tag, "_xfer_count"}, tx_log.size(), 3 + n);
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), tx_log[i], exp_tx[i]);
        chk({tag, "_wt_count"}, wt_log.size(), n);
        for (int i = 0; i < n && i < wt_log.size() &&
                        (1 + NAB + i) < rx_log.size(); i++)
            chk($sformatf("%s_wt%0d", tag, i), wt_log[i], rx_log[1 + NAB + i]);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_no_overlap"}, overlap_viol, 0);
        chk({tag, "_stall_stable"}, stall_viol, 0);
        chk({tag, "_tx_held"}, hold_viol, 0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        logic [15:0] a;
        int n, c;
        clear_logs();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_start", spi_start, 1'b0);
        chk("rst_wt_valid", wt_valid, 1'b0);
        chk("rst_tx", spi_tx_data, 8'h00);
        chk("rst_wt_data", wt_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic read of two bytes with known replies.
        clear_logs();
        rmode = 0;
        rx_src = '{8'h11, 8'h22, 8'h33, 8'hA5, 8'h5A};
        fetch(16'h1234, 8'd2);
        wait_done("basic");
        check_fetch("basic", 16'h1234, 2);
        chk("basic_wt0_const", wt_log.size() > 0 ? wt_log[0] : 8'hxx, 8'hA5);
        chk("basic_wt1_const", wt_log.size() > 1 ? wt_log[1] : 8'hxx, 8'h5A);

        // Zero length: immediate done, no SPI traffic.
        clear_logs();
        fetch(16'hBEEF, 8'd0);
        chk("len0_done_t1", done, 1'b1);
        @(posedge clk);
        #2;
        chk("len0_busy_clear", busy, 1'b0);
        chk("len0_done_clear", done, 1'b0);
        chk("len0_no_start", start_cnt, 0);
        chk("len0_no_valid", valid_cnt, 0);
        chk("len0_done_count", done_cnt, 1);

        // Request held through FIN is ignored there, accepted in the next IDLE.
        @(posedge clk);
        #2;
        fetch_req = 1'b1;
        fetch_len = 8'd0;
        @(posedge clk);
        #2;
        chk("hold_req_done1", done, 1'b1);
        @(posedge clk);
        #2;
        chk("hold_req_fin_ignored", done, 1'b0);
        chk("hold_req_idle_busy", busy, 1'b0);
        @(posedge clk);
        #2;
        chk("hold_req_done2", done, 1'b1);
        fetch_req = 1'b0;
        repeat (2) @(posedge clk);

        // Consumer stall after the first byte.
        clear_logs();
        stall_left = 20;
        rmode = 2;
        a = 16'($urandom);
        fetch(a, 8'd3);
        wait_done("stall");
        check_fetch("stall", a, 3);
        chk("stall_valid_cycles_ge", valid_cnt >= 23, 1'b1);
        rmode = 0;

        // Request while busy is ignored.
        clear_logs();
        rmode = 1;
        a = 16'($urandom);
        fetch(a, 8'd4);
        repeat (3) @(posedge clk);
        #2;
        fetch_req = 1'b1;
        fetch_addr = 16'hFFFF;
        fetch_len = 8'd7;
        @(posedge clk);
        #2;
        fetch_req = 1'b0;
        wait_done("busyreq");
        check_fetch("busyreq", a, 4);
        rmode = 0;

        // Reset during the wait on the first address byte.
        clear_logs();
        lat_min = 6;
        lat_max = 6;
        fetch(16'h5AA5, 8'd2);
        c = 0;
        while (start_cnt < 2 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("rst_mid_reached_addr", start_cnt, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_start", spi_start, 1'b0);
        chk("rstmid_tx", spi_tx_data, 8'h00);
        chk("rstmid_done", done, 1'b0);
        chk("rstmid_wt_valid", wt_valid, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        lat_min = 0;
        lat_max = 3;
        clear_logs();
        a = 16'($urandom);
        fetch(a, 8'd2);
        wait_done("after_rst");
        check_fetch("after_rst", a, 2);

        // Randomised fetches with random backpressure.
        rmode = 1;
        for (int k = 0; k < 4; k++) begin
            clear_logs();
            a = 16'($urandom);
            n = $urandom_range(6, 1);
            fetch(a, 8'(n));
            wait_done($sformatf("rnd%0d", k));
            check_fetch($sformatf("rnd%0d", k), a, n);
        end
        rmode = 0;

`ifdef SPI_FETCH_TIMEOUT_EN
        clear_logs();
        resp_en = 1'b0;
        fetch(16'h0F0F, 8'd1);
        c = 0;
        while (spi_start !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (done !== 1'b1 && c < 300);
        chk("to_latency", c, TO + 1);
        chk("to_err", err, 1'b1);
        chk("to_no_wt", valid_cnt, 0);
        resp_en = 1'b1;
        @(negedge clk);
        clear_logs();
        a = 16'($urandom);
        fetch(a, 8'd1);
        chk("to_err_cleared", err, 1'b0);
        wait_done("to_next");
        check_fetch("to_next", a, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
